alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter TAG_WIDTH, default 6, destination tag width, matching the writeback broadcast tag.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 issue_valid  input  1  issue request from reservation station.
REQ-006 issue_instruction  input  32  RV32I instruction word.
REQ-007 issue_rs1_data / issue_rs2_data  input  DATA_WIDTH each  source operands.
REQ-008 issue_tag  input  TAG_WIDTH  destination tag of instruction.
REQ-009 issue_ready  output  1  unit accepts issue this cycle.
REQ-010 flush  input  1  discard all in-flight work.
REQ-011 wb_valid  output  1  result broadcast valid.
REQ-012 wb_tag / wb_data  output  TAG_WIDTH / DATA_WIDTH  broadcast tag and result.
REQ-013 wb_exception  output  1  instruction unsupported; wb_data is 0.
REQ-014 wb_ready  input  1  broadcast bus grant; transfer on wb_valid && wb_ready.

Function
REQ-015 Two-stage pipeline: S1 latches decoded op, operand A, operand B, tag; S2 latches result, tag, exception.
REQ-016 Latency: issue accepted cycle N -> wb_valid in cycle N+2 when no backpressure.
REQ-017 Throughput one instruction/cycle with wb_ready held 1.
REQ-018 s2_free = !s2_valid || wb_ready; S1 advances when s1_valid && s2_free; issue_ready = !flush && (!s1_valid || s2_free).
REQ-019 wb_valid, wb_tag, wb_data, wb_exception hold stable while wb_valid && !wb_ready.
REQ-020 Supported: OP (0110011) ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; OP-IMM (0010011) ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; LUI (0110111).
REQ-021 OP-IMM operand B = sign-extended inst[31:20]; LUI result = {inst[31:12], 12'b0}.
REQ-022 SUB/SRA selected by inst[30] on OP; SRAI by inst[30] on OP-IMM; ADDI ignores inst[30].
REQ-023 Shift amount = operand B[4:0]; arithmetic modulo 2^DATA_WIDTH, no overflow flag.
REQ-024 SLT/SLTU result is 0 or 1, zero-extended.
REQ-025 Unsupported opcode, or funct7 other than 0000000/0100000 where defined -> wb_exception=1, wb_data=0, tag still broadcast.
REQ-026 flush=1 in cycle N: s1_valid and s2_valid = 0 from N+1; issue_ready=0 in N; no issue accepted in N; wb_valid in N unaffected combinationally.
REQ-027 Simultaneous S2 drain and S1 advance in same cycle: S2 reloads, no bubble.
REQ-028 S1 stalled with S2 stalled: S1 contents held, issue_ready=0.

Reset
REQ-029 rst_n low: s1_valid=0, s2_valid=0 immediately (asynchronous).
REQ-030 Reset values: wb_valid=0, wb_tag=0, wb_data=0, wb_exception=0; issue_ready=1 after deassertion.
REQ-031 Reset mid-operation drops all in-flight instructions; no broadcast after release until new issue.

Structure
REQ-032 Opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI) and alu_op_t enum live in shared package ooo_pkg.
REQ-033 Combinational compute in sub-module alu_core (inputs alu_op_t, A, B; output result), instantiated between S1 and S2.
REQ-034 No storage beyond two pipeline registers.

Verification
REQ-035 Issue ADD rs1=5 rs2=7 tag=3, wb_ready=1 -> wb_valid two cycles later, wb_tag=3, wb_data=12, wb_exception=0.
REQ-036 Back-to-back SUB 0-1 (tag 1), SRAI 0x80000000>>4 (tag 2), SLTU 1<2 (tag 3) -> data 0xFFFFFFFF, 0xF8000000, 1 on consecutive cycles.
REQ-037 wb_ready=0 for 5 cycles with 3 issues -> issue_ready drops after 2 accepted, wb outputs stable, results drain in order on release.
REQ-038 flush asserted with S1 and S2 valid -> no wb_valid next cycle, issue_ready=0 during flush, later issue completes normally.
REQ-039 Opcode 1111111 tag=9 -> wb_valid, wb_tag=9, wb_exception=1, wb_data=0.
REQ-040 rst_n asserted mid-stream -> wb_valid=0 asynchronously; issue_ready=1 first cycle after release.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order core: RV32I opcode constants,
// ALU operation encoding and the integer-instruction decoder used at issue.
package ooo_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_ZERO  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    BSEL_RS2 = 2'd0,
    BSEL_IMM = 2'd1,
    BSEL_LUI = 2'd2
  } bsel_t;

  typedef struct packed {
    alu_op_t op;
    bsel_t   bsel;
    logic    exc;
  } dec_t;

  function automatic alu_op_t funct3_op(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // OP-IMM only honours inst[30] for right shifts; elsewhere it is an immediate bit.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       f7_ok;
    f7     = inst[31:25];
    f3     = inst[14:12];
    f7_ok  = (f7 == F7_BASE) || (f7 == F7_ALT);
    d.op   = ALU_ZERO;
    d.bsel = BSEL_RS2;
    d.exc  = 1'b1;
    case (inst[6:0])
      OPC_OP: begin
        d.bsel = BSEL_RS2;
        d.exc  = !f7_ok;
        d.op   = funct3_op(f3, inst[30]);
      end
      OPC_OP_IMM: begin
        d.bsel = BSEL_IMM;
        d.exc  = ((f3 == 3'b001) || (f3 == 3'b101)) && !f7_ok;
        d.op   = funct3_op(f3, (f3 == 3'b101) && inst[30]);
      end
      OPC_LUI: begin
        d.bsel = BSEL_LUI;
        d.exc  = 1'b0;
        d.op   = ALU_PASSB;
      end
      default: begin
        d.bsel = BSEL_RS2;
        d.exc  = 1'b1;
        d.op   = ALU_ZERO;
      end
    endcase
    d.op = d.exc ? ALU_ZERO : d.op;
    return d;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU between the two pipeline stages.
// Shifts use only the low five bits of operand B; arithmetic wraps.
module alu_core
  import ooo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_op_t               i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];

  // Result select by operation
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SLT:   o_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_result = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SRL:   o_result = i_a >> w_shamt;
      ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_PASSB: o_result = i_b;
      ALU_ZERO:  o_result = '0;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage integer execution unit: S1 holds the decoded op and operands,
// S2 holds the result for the writeback broadcast bus with valid/ready backpressure.
module alu_exec_unit
  import ooo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [31:0]           issue_instruction,
  input  logic [DATA_WIDTH-1:0] issue_rs1_data,
  input  logic [DATA_WIDTH-1:0] issue_rs2_data,
  input  logic [TAG_WIDTH-1:0]  issue_tag,
  output logic                  issue_ready,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic [TAG_WIDTH-1:0]  wb_tag,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_exception,
  input  logic                  wb_ready
);

  dec_t                  w_dec;
  logic [DATA_WIDTH-1:0] w_opb;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_s2_free;
  logic                  w_s1_adv;
  logic                  w_issue_fire;

  logic                  r_s1_valid;
  alu_op_t               r_s1_op;
  logic                  r_s1_exc;
  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [DATA_WIDTH-1:0] r_s1_b;
  logic [TAG_WIDTH-1:0]  r_s1_tag;

  logic                  r_s2_valid;
  logic [TAG_WIDTH-1:0]  r_s2_tag;
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic                  r_s2_exc;

  assign w_dec        = decode(issue_instruction);
  assign w_s2_free    = !r_s2_valid || wb_ready;
  assign w_s1_adv     = r_s1_valid && w_s2_free;
  assign issue_ready  = !flush && (!r_s1_valid || w_s2_free);
  assign w_issue_fire = issue_valid && issue_ready;

  // Operand B source: register, sign-extended I-immediate, or the LUI upper immediate
  always_comb begin
    w_opb = issue_rs2_data;
    case (w_dec.bsel)
      BSEL_IMM: w_opb = DATA_WIDTH'($signed(issue_instruction[31:20]));
      BSEL_LUI: w_opb = DATA_WIDTH'($signed({issue_instruction[31:12], 12'h000}));
      default:  w_opb = issue_rs2_data;
    endcase
  end

  // Stage 1 register: load on accepted issue, empty when handed to S2 or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= ALU_ZERO;
      r_s1_exc   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_issue_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= w_dec.op;
      r_s1_exc   <= w_dec.exc;
      r_s1_a     <= issue_rs1_data;
      r_s1_b     <= w_opb;
      r_s1_tag   <= issue_tag;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_core (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_alu_result)
  );

  // Stage 2 register: reloads in the same cycle it drains so back-to-back results have no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_data  <= '0;
      r_s2_exc   <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_tag   <= r_s1_tag;
      r_s2_data  <= r_s1_exc ? '0 : w_alu_result;
      r_s2_exc   <= r_s1_exc;
    end else if (wb_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign wb_valid     = r_s2_valid;
  assign wb_tag       = r_s2_tag;
  assign wb_data      = r_s2_data;
  assign wb_exception = r_s2_exc;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scenario bench for alu_exec_unit: expected results are queued at issue and
// compared in order against captured writeback transfers.
module tb_alu_exec_unit;
  import ooo_pkg::*;

  localparam int DW = 32;
  localparam int TW = 6;

  logic          clk               = 1'b0;
  logic          rst_n             = 1'b0;
  logic          issue_valid       = 1'b0;
  logic [31:0]   issue_instruction = 32'd0;
  logic [DW-1:0] issue_rs1_data    = 32'd0;
  logic [DW-1:0] issue_rs2_data    = 32'd0;
  logic [TW-1:0] issue_tag         = 6'd0;
  logic          flush             = 1'b0;
  logic          wb_ready          = 1'b0;
  logic          issue_ready;
  logic          wb_valid;
  logic [TW-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic          wb_exception;

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   data;
    logic          exc;
    int            cyc;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   got_rd   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  alu_exec_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .issue_valid       (issue_valid),
    .issue_instruction (issue_instruction),
    .issue_rs1_data    (issue_rs1_data),
    .issue_rs2_data    (issue_rs2_data),
    .issue_tag         (issue_tag),
    .issue_ready       (issue_ready),
    .flush             (flush),
    .wb_valid          (wb_valid),
    .wb_tag            (wb_tag),
    .wb_data           (wb_data),
    .wb_exception      (wb_exception),
    .wb_ready          (wb_ready)
  );

  always #5 clk = ~clk;

  // Mid-cycle capture of every broadcast transfer, stamped with the cycle number
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wb_valid && wb_ready)
      got_q.push_back('{tag: wb_tag, data: wb_data, exc: wb_exception, cyc: cyc});
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  // Reference behaviour of RV32I integer ops; returns {exception, data}
  function automatic logic [32:0] ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] op2;
    logic [31:0] d;
    logic        exc;
    logic        f7_ok;
    opc   = ins[6:0];
    f7    = ins[31:25];
    f3    = ins[14:12];
    f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
    exc   = 1'b0;
    d     = 32'd0;
    op2   = (opc == 7'b0110011) ? b : {{20{ins[31]}}, ins[31:20]};
    if (opc == 7'b0110111) begin
      d = {ins[31:12], 12'h000};
    end else if (opc == 7'b0110011 || opc == 7'b0010011) begin
      if (opc == 7'b0110011 && !f7_ok) exc = 1'b1;
      if (opc == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5) && !f7_ok) exc = 1'b1;
      case (f3)
        3'd0:    d = (opc == 7'b0110011 && ins[30]) ? a - op2 : a + op2;
        3'd1:    d = a << op2[4:0];
        3'd2:    d = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
        3'd3:    d = (a < op2) ? 32'd1 : 32'd0;
        3'd4:    d = a ^ op2;
        3'd5:    d = ins[30] ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
        3'd6:    d = a | op2;
        default: d = a & op2;
      endcase
    end else begin
      exc = 1'b1;
    end
    if (exc) d = 32'd0;
    return {exc, d};
  endfunction

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             input logic [TW-1:0] tag, input logic [31:0] ed, input logic ee,
                             output logic acc);
    issue_valid       = 1'b1;
    issue_instruction = ins;
    issue_rs1_data    = a;
    issue_rs2_data    = b;
    issue_tag         = tag;
    @(negedge clk);
    acc = issue_ready;
    if (acc) exp_q.push_back('{tag: tag, data: ed, exc: ee, cyc: 0});
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
    n_checks++;
    if (wb_tag !== 6'd0) begin n_fail++; $display("FAIL reset_wb_tag: got %0d want 0", wb_tag); end
    n_checks++;
    if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data: got %08h want 0", wb_data); end
    n_checks++;
    if (wb_exception !== 1'b0) begin n_fail++; $display("FAIL reset_wb_exc: got %0b want 0", wb_exception); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %0b want 1", issue_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    logic acc;
    res_t e;
    res_t g;
    wb_ready = 1'b1;
    drive_issue(enc_r(7'h00, 3'd0), 32'd5, 32'd7, 6'd3, 32'd12, 1'b0, acc);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL add_accept: got %0b want 1", acc); end
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %0b want 0 at N+1", wb_valid); end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_tag !== 6'd3 || wb_data !== 32'd12 || wb_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency: got v=%0b tag=%0d data=%0d exc=%0b want v=1 tag=3 data=12 exc=0",
               wb_valid, wb_tag, wb_data, wb_exception);
    end
    @(posedge clk);
    #1;
    repeat (3) tick();
    n_checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      n_fail++; $display("FAIL add_count: got %0d results want %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      n_checks++;
      if (g.tag !== e.tag || g.data !== e.data || g.exc !== e.exc) begin
        n_fail++; $display("FAIL add_sb: got tag=%0d data=%08h exc=%0b want tag=%0d data=%08h exc=%0b",
                           g.tag, g.data, g.exc, e.tag, e.data, e.exc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   acc_cnt;
    int   base;
    res_t e;
    res_t g;
    wb_ready = 1'b1;
    acc_cnt  = 0;
    base     = got_rd;
    drive_issue(enc_r(7'h20, 3'd0), 32'd0, 32'd1, 6'd1, 32'hFFFF_FFFF, 1'b0, acc);
    acc_cnt += int'(acc);
    drive_issue(enc_i({7'h20, 5'd4}, 3'd5), 32'h8000_0000, 32'd0, 6'd2, 32'hF800_0000, 1'b0, acc);
    acc_cnt += int'(acc);
    drive_issue(enc_r(7'h00, 3'd3), 32'd1, 32'd2, 6'd3, 32'd1, 1'b0, acc);
    acc_cnt += int'(acc);
    n_checks++;
    if (acc_cnt != 3) begin n_fail++; $display("FAIL b2b_accept: got %0d accepted want 3", acc_cnt); end
    repeat (4) tick();
    n_checks++;
    if (got_q.size() - base != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 3", got_q.size() - base);
    end else begin
      n_checks++;
      if (got_q[base+1].cyc != got_q[base].cyc + 1 || got_q[base+2].cyc != got_q[base].cyc + 2) begin
        n_fail++; $display("FAIL b2b_consecutive: got cycles %0d %0d %0d want consecutive",
                           got_q[base].cyc, got_q[base+1].cyc, got_q[base+2].cyc);
      end
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      n_checks++;
      if (g.tag !== e.tag || g.data !== e.data || g.exc !== e.exc) begin
        n_fail++; $display("FAIL b2b_sb: got tag=%0d data=%08h exc=%0b want tag=%0d data=%08h exc=%0b",
                           g.tag, g.data, g.exc, e.tag, e.data, e.exc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_alu_ops();
    logic [31:0] ops[17];
    logic [32:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic        acc;
    res_t        e;
    res_t        g;
    ops = '{enc_r(7'h00, 3'd0), enc_r(7'h00, 3'd1), enc_r(7'h00, 3'd2), enc_r(7'h00, 3'd4),
            enc_r(7'h00, 3'd5), enc_r(7'h20, 3'd5), enc_r(7'h00, 3'd6), enc_r(7'h00, 3'd7),
            enc_i(12'h400, 3'd0), enc_i(12'hFFF, 3'd2), enc_i(12'h800, 3'd3), enc_i(12'h5A5, 3'd4),
            enc_i(12'h0F0, 3'd6), enc_i(12'h80F, 3'd7), enc_i(12'h01F, 3'd1), enc_i(12'h01F, 3'd5),
            {20'hABCDE, 5'd3, 7'b0110111}};
    wb_ready = 1'b1;
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < 17; i++) begin
        a = (pass == 0) ? 32'h8000_0000 : $urandom();
        b = (pass == 0) ? 32'h7FFF_FFFF : $urandom();
        r = ref_exec(ops[i], a, b);
        drive_issue(ops[i], a, b, TW'(i + 20 * pass), r[31:0], r[32], acc);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL ops_accept: op %0d got %0b want 1", i, acc); end
      end
    end
    repeat (4) tick();
    n_checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      n_fail++; $display("FAIL ops_count: got %0d results want %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      n_checks++;
      if (g.tag !== e.tag || g.data !== e.data || g.exc !== e.exc) begin
        n_fail++; $display("FAIL ops_sb: got tag=%0d data=%08h exc=%0b want tag=%0d data=%08h exc=%0b",
                           g.tag, g.data, g.exc, e.tag, e.data, e.exc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_exception();
    logic acc;
    res_t e;
    res_t g;
    wb_ready = 1'b1;
    drive_issue(32'h0000_007F, 32'd11, 32'd22, 6'd9, 32'd0, 1'b1, acc);
    drive_issue(enc_r(7'h01, 3'd0), 32'd3, 32'd4, 6'd10, 32'd0, 1'b1, acc);
    drive_issue(enc_i({7'h01, 5'd3}, 3'd1), 32'd3, 32'd0, 6'd11, 32'd0, 1'b1, acc);
    drive_issue(enc_r(7'h00, 3'd0), 32'd3, 32'd4, 6'd12, 32'd7, 1'b0, acc);
    repeat (4) tick();
    n_checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      n_fail++; $display("FAIL exc_count: got %0d results want %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      n_checks++;
      if (g.tag !== e.tag || g.data !== e.data || g.exc !== e.exc) begin
        n_fail++; $display("FAIL exc_sb: got tag=%0d data=%08h exc=%0b want tag=%0d data=%08h exc=%0b",
                           g.tag, g.data, g.exc, e.tag, e.data, e.exc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0]   ins[3];
    logic [31:0]   av[3];
    logic [31:0]   bv[3];
    logic [31:0]   ev[3];
    logic [TW-1:0] tv[3];
    int            k;
    res_t          e;
    res_t          g;
    ins = '{enc_r(7'h00, 3'd0), enc_r(7'h00, 3'd4), enc_r(7'h00, 3'd6)};
    av  = '{32'd10, 32'h0000_F0F0, 32'd1};
    bv  = '{32'd20, 32'h0000_FF00, 32'd2};
    ev  = '{32'd30, 32'h0000_0FF0, 32'd3};
    tv  = '{6'd20, 6'd21, 6'd22};
    k   = 0;
    wb_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      issue_valid       = 1'b1;
      issue_instruction = ins[k];
      issue_rs1_data    = av[k];
      issue_rs2_data    = bv[k];
      issue_tag         = tv[k];
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %0b want 0", issue_ready); end
      end
      if (c >= 2) begin
        n_checks++;
        if (wb_valid !== 1'b1 || wb_tag !== tv[0] || wb_data !== ev[0] || wb_exception !== 1'b0) begin
          n_fail++; $display("FAIL bp_hold: cycle %0d got v=%0b tag=%0d data=%08h want v=1 tag=%0d data=%08h",
                             c, wb_valid, wb_tag, wb_data, tv[0], ev[0]);
        end
      end
      if (issue_ready) begin
        exp_q.push_back('{tag: tv[k], data: ev[k], exc: 1'b0, cyc: 0});
        k++;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (k != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", k); end
    wb_ready = 1'b1;
    for (int c = 0; c < 10 && k < 3; c++) begin
      issue_valid       = 1'b1;
      issue_instruction = ins[k];
      issue_rs1_data    = av[k];
      issue_rs2_data    = bv[k];
      issue_tag         = tv[k];
      @(negedge clk);
      if (issue_ready) begin
        exp_q.push_back('{tag: tv[k], data: ev[k], exc: 1'b0, cyc: 0});
        k++;
      end
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    n_checks++;
    if (k != 3) begin n_fail++; $display("FAIL bp_release_accept: got %0d want 3", k); end
    repeat (5) tick();
    n_checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d results want %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      n_checks++;
      if (g.tag !== e.tag || g.data !== e.data || g.exc !== e.exc) begin
        n_fail++; $display("FAIL bp_sb: got tag=%0d data=%08h exc=%0b want tag=%0d data=%08h exc=%0b",
                           g.tag, g.data, g.exc, e.tag, e.data, e.exc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_flush();
    logic acc;
    int   acc_cnt;
    res_t e;
    res_t g;
    wb_ready = 1'b0;
    acc_cnt  = 0;
    drive_issue(enc_r(7'h00, 3'd0), 32'd1, 32'd1, 6'd30, 32'd2, 1'b0, acc);
    acc_cnt += int'(acc);
    drive_issue(enc_r(7'h00, 3'd0), 32'd2, 32'd2, 6'd31, 32'd4, 1'b0, acc);
    acc_cnt += int'(acc);
    n_checks++;
    if (acc_cnt != 2) begin n_fail++; $display("FAIL flush_fill: got %0d accepted want 2", acc_cnt); end
    flush             = 1'b1;
    issue_valid       = 1'b1;
    issue_instruction = enc_r(7'h00, 3'd0);
    issue_tag         = 6'd32;
    @(negedge clk);
    n_checks++;
    if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b want 0", issue_ready); end
    n_checks++;
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL flush_wb_same_cycle: got %0b want 1", wb_valid); end
    @(posedge clk);
    #1;
    flush       = 1'b0;
    issue_valid = 1'b0;
    wb_ready    = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wb_after: got %0b want 0", wb_valid); end
    @(posedge clk);
    #1;
    repeat (3) tick();
    n_checks++;
    if (got_q.size() != got_rd) begin
      n_fail++; $display("FAIL flush_no_broadcast: got %0d results want 0", got_q.size() - got_rd);
    end
    got_rd = got_q.size();
    drive_issue(enc_r(7'h20, 3'd0), 32'd10, 32'd3, 6'd33, 32'd7, 1'b0, acc);
    repeat (4) tick();
    n_checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      n_fail++; $display("FAIL flush_count: got %0d results want %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      n_checks++;
      if (g.tag !== e.tag || g.data !== e.data || g.exc !== e.exc) begin
        n_fail++; $display("FAIL flush_sb: got tag=%0d data=%08h exc=%0b want tag=%0d data=%08h exc=%0b",
                           g.tag, g.data, g.exc, e.tag, e.data, e.exc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic acc;
    wb_ready = 1'b0;
    drive_issue(enc_r(7'h00, 3'd0), 32'd4, 32'd4, 6'd40, 32'd8, 1'b0, acc);
    drive_issue(enc_r(7'h00, 3'd0), 32'd5, 32'd5, 6'd41, 32'd10, 1'b0, acc);
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %0b want 1", wb_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_tag !== 6'd0) begin
      n_fail++; $display("FAIL rst_mid_async: got v=%0b tag=%0d want v=0 tag=0", wb_valid, wb_tag);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %0b want 1", issue_ready); end
    @(posedge clk);
    #1;
    repeat (3) tick();
    n_checks++;
    if (got_q.size() != got_rd) begin
      n_fail++; $display("FAIL rst_mid_no_broadcast: got %0d results want 0", got_q.size() - got_rd);
    end
    got_rd = got_q.size();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_exception();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
